// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_if
// Brief    : Loader, run-control, hazard and IF/ID signals of the fetch stage.
//            The master side is the debug unit plus the decode/hazard logic;
//            the slave side is the fetch unit itself.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if #(
  parameter int NBITS     = 32,
  parameter int MEM_DEPTH = 256
);
  localparam int c_cnt_w = $clog2(MEM_DEPTH) + 1;

  // Loader / run control
  logic               i_load_start;
  logic               i_load_en;
  logic [NBITS-1:0]   i_load_data;
  logic               i_start;
  logic               i_step_mode;
  logic               i_step;
  // Pipeline control
  logic               i_stall;
  logic               i_flush;
  logic               i_redirect;
  logic [NBITS-1:0]   i_redirect_addr;
  // IF/ID register and status
  logic [NBITS-1:0]   o_pc;
  logic [NBITS-1:0]   o_pc_plus4;
  logic [NBITS-1:0]   o_instr;
  logic               o_valid;
  logic               o_halted;
  logic [c_cnt_w-1:0] o_load_count;
  logic               o_load_full;
  logic               o_addr_err;

  modport master (
    output i_load_start, i_load_en, i_load_data, i_start, i_step_mode, i_step,
    output i_stall, i_flush, i_redirect, i_redirect_addr,
    input  o_pc, o_pc_plus4, o_instr, o_valid, o_halted,
    input  o_load_count, o_load_full, o_addr_err
  );

  modport slave (
    input  i_load_start, i_load_en, i_load_data, i_start, i_step_mode, i_step,
    input  i_stall, i_flush, i_redirect, i_redirect_addr,
    output o_pc, o_pc_plus4, o_instr, o_valid, o_halted,
    output o_load_count, o_load_full, o_addr_err
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : MIPS instruction-fetch stage: PC, debug-loadable instruction
//            memory, IF/ID register, stall/redirect/flush handling, single
//            step, halt-word detection and sticky fetch-address error.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int               NBITS      = 32,
  parameter int               MEM_DEPTH  = 256,
  parameter logic [NBITS-1:0] RESET_PC   = '0,
  parameter logic [NBITS-1:0] HALT_INSTR = '1
) (
  input wire logic               i_clk,
  input wire logic               i_rst,
  instruction_fetch_unit_if.slave bus
);

  localparam int c_aw = $clog2(MEM_DEPTH);

  localparam logic [1:0] c_st_load = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_halt = 2'd2;

  localparam logic [1:0] c_ifid_hold  = 2'd0;
  localparam logic [1:0] c_ifid_clear = 2'd1;
  localparam logic [1:0] c_ifid_load  = 2'd2;

  localparam logic [c_aw:0]    c_depth_cnt  = (c_aw + 1)'(MEM_DEPTH);
  localparam logic [NBITS:0]   c_addr_limit = (NBITS + 1)'(4 * MEM_DEPTH);
  localparam logic [NBITS-1:0] c_four       = NBITS'(4);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [NBITS-1:0] r_pc;
  logic             r_step_pend;
  logic             r_addr_err;
  logic [c_aw:0]    r_load_count;
  logic [NBITS-1:0] r_mem [MEM_DEPTH];

  logic [NBITS-1:0] r_ifid_pc;
  logic [NBITS-1:0] r_ifid_pc4;
  logic [NBITS-1:0] r_ifid_instr;
  logic             r_ifid_valid;

  logic [NBITS-1:0] w_pc_plus4;
  logic [c_aw-1:0]  w_rd_idx;
  logic [NBITS-1:0] w_rd_word;
  logic             w_is_halt;
  logic             w_addr_bad;
  logic             w_fetch_en;
  logic             w_wr_en;
  logic [c_aw-1:0]  w_wr_idx;

  logic [NBITS-1:0] w_pc_next;
  logic [1:0]       w_ifid_op;
  logic             w_pend_next;
  logic             w_err_set;

  // Words above the load pointer were never written in this session: read NOP.
  assign w_pc_plus4 = r_pc + c_four;
  assign w_rd_idx   = r_pc[c_aw+1:2];
  assign w_rd_word  = ({1'b0, w_rd_idx} < r_load_count) ? r_mem[w_rd_idx] : '0;
  assign w_is_halt  = (w_rd_word == HALT_INSTR);
  assign w_addr_bad = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} >= c_addr_limit);
  assign w_fetch_en = !bus.i_step_mode || bus.i_step || r_step_pend;

  // A load_start restarts the session, so its companion write lands in word 0.
  assign w_wr_en  = bus.i_load_en &&
                    (bus.i_load_start ||
                     (r_state == c_st_load && r_load_count != c_depth_cnt));
  assign w_wr_idx = bus.i_load_start ? '0 : r_load_count[c_aw-1:0];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= c_st_load;
    else        r_state <= w_state_next;
  end

  // Next state: load_start from anywhere, halt on halt word or bad fetch address.
  always_comb begin
    w_state_next = r_state;
    if (bus.i_load_start) begin
      w_state_next = c_st_load;
    end else begin
      case (r_state)
        c_st_load: if (bus.i_start) w_state_next = c_st_run;
        c_st_run: begin
          if (!bus.i_redirect && !bus.i_stall && w_fetch_en &&
              (w_addr_bad || w_is_halt))
            w_state_next = c_st_halt;
        end
        c_st_halt: w_state_next = c_st_halt;
        default:   w_state_next = c_st_load;
      endcase
    end
  end

  // Per-cycle control decode: redirect > stall > fetch > bubble.
  always_comb begin
    w_pc_next   = r_pc;
    w_ifid_op   = c_ifid_hold;
    w_pend_next = r_step_pend;
    w_err_set   = 1'b0;
    if (bus.i_load_start) begin
      w_pc_next   = RESET_PC;
      w_ifid_op   = c_ifid_clear;
      w_pend_next = 1'b0;
    end else begin
      case (r_state)
        c_st_run: begin
          if (bus.i_redirect) begin
            w_pc_next   = bus.i_redirect_addr;
            w_ifid_op   = c_ifid_clear;
            w_pend_next = 1'b0;
          end else if (bus.i_stall) begin
            if (bus.i_flush) w_ifid_op = c_ifid_clear;
            if (bus.i_step)  w_pend_next = 1'b1;
          end else if (w_fetch_en) begin
            w_pend_next = 1'b0;
            if (w_addr_bad) begin
              w_ifid_op = c_ifid_clear;
              w_err_set = 1'b1;
            end else begin
              w_ifid_op = bus.i_flush ? c_ifid_clear : c_ifid_load;
              // The PC parks on a halt word so it stays visible for debug.
              if (!w_is_halt) w_pc_next = w_pc_plus4;
            end
          end else begin
            w_ifid_op = c_ifid_clear;
          end
        end
        c_st_halt: begin
          w_ifid_op = c_ifid_clear;
          if (bus.i_step) w_pend_next = 1'b1;
        end
        default: begin
          if (bus.i_step) w_pend_next = 1'b1;
        end
      endcase
    end
  end

  // PC, step latch, sticky error and load pointer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc         <= RESET_PC;
      r_step_pend  <= 1'b0;
      r_addr_err   <= 1'b0;
      r_load_count <= '0;
    end else begin
      r_pc        <= w_pc_next;
      r_step_pend <= w_pend_next;
      if (bus.i_load_start)  r_addr_err <= 1'b0;
      else if (w_err_set)    r_addr_err <= 1'b1;
      if (bus.i_load_start)  r_load_count <= bus.i_load_en ? (c_aw + 1)'(1) : '0;
      else if (w_wr_en)      r_load_count <= r_load_count + (c_aw + 1)'(1);
    end
  end

  // Instruction memory write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= bus.i_load_data;
  end

  // IF/ID pipeline register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (w_ifid_op)
        c_ifid_clear: begin
          r_ifid_pc    <= '0;
          r_ifid_pc4   <= '0;
          r_ifid_instr <= '0;
          r_ifid_valid <= 1'b0;
        end
        c_ifid_load: begin
          r_ifid_pc    <= r_pc;
          r_ifid_pc4   <= w_pc_plus4;
          r_ifid_instr <= w_rd_word;
          r_ifid_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_pc         = r_ifid_pc;
  assign bus.o_pc_plus4   = r_ifid_pc4;
  assign bus.o_instr      = r_ifid_instr;
  assign bus.o_valid      = r_ifid_valid;
  assign bus.o_halted     = (r_state == c_st_halt);
  assign bus.o_load_count = r_load_count;
  assign bus.o_load_full  = (r_load_count == c_depth_cnt);
  assign bus.o_addr_err   = r_addr_err;

endmodule
`default_nettype wire
